lsm_sequencer: RTL and testbench

LSM_SEQUENCER -- requirements
Module: lsm_sequencer

---
 rtl/lsm_pkg.sv | 22 ++
 rtl/lsm_sequencer_if.sv | 26 ++
 rtl/lsm_prio_enc.sv | 20 ++
 rtl/lsm_sequencer.sv | 139 +++++++++++++
 tb/tb_lsm_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsm_pkg.sv
// Shared encodings for the load/store-multiple sequencer and the control-unit microcode.
package lsm_pkg;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_NEXT  = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b011;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACTIVE = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lsm_sequencer_if.sv
// Control-unit <-> sequencer signal bundle; master is the control unit, slave the sequencer.
interface lsm_sequencer_if (input logic clk);

    logic [31:0] ir;
    logic        lsm_en;
    logic [2:0]  lsm_in;
    logic        lsm_detect;
    logic        lsm_end;
    logic [3:0]  reg_num;
    logic [4:0]  cnt;
    logic [7:0]  start_offset;
    logic [7:0]  wb_offset;

    modport master (
        input  clk,
        output ir, lsm_en, lsm_in,
        input  lsm_detect, lsm_end, reg_num, cnt, start_offset, wb_offset
    );

    modport slave (
        input  clk,
        input  ir, lsm_en, lsm_in,
        output lsm_detect, lsm_end, reg_num, cnt, start_offset, wb_offset
    );

endinterface

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
module lsm_prio_enc (
    input  logic [15:0] vec,
    output logic [3:0]  index,
    output logic        valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                index = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsm_sequencer.sv
// Block data transfer sequencer: walks the register list of an LDM/STM one register per NEXT
// and provides the start/writeback byte offsets computed at LOAD.
module lsm_sequencer
    import lsm_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IR,
    input  logic        LSM_EN,
    input  logic [2:0]  LSM_IN,
    output logic        LSM_DETECT,
    output logic        LSM_END,
    output logic [3:0]  REG_NUM,
    output logic [4:0]  CNT,
    output logic [7:0]  START_OFFSET,
    output logic [7:0]  WB_OFFSET
);

    logic [1:0]  state_q, state_d;
    logic [15:0] list_q, list_d;
    logic [3:0]  reg_num_q, reg_num_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  start_off_q, start_off_d;
    logic [7:0]  wb_off_q, wb_off_d;
    logic        end_q, end_d;

    logic [4:0]  load_n;
    logic [7:0]  four_n, neg_four_n;
    logic [7:0]  load_start, load_wb;
    logic [3:0]  load_idx, next_idx;
    logic        load_vld;
    logic        unused_next_vld;
    logic [15:0] list_clr;
    logic        unused_ir_bits;

    assign unused_ir_bits = ^{IR[31:28], IR[22:16]};
    assign LSM_DETECT     = (IR[27:25] == 3'b100);

    assign load_n     = popcount16(IR[15:0]);
    assign four_n     = {1'b0, load_n, 2'b00};
    assign neg_four_n = 8'd0 - four_n;

    // P=IR[24] selects before/after, U=IR[23] selects up/down.
    always_comb begin
        load_start = '0;
        load_wb    = IR[23] ? four_n : neg_four_n;
        case ({IR[24], IR[23]})
            2'b01:   load_start = 8'd0;
            2'b11:   load_start = 8'd4;
            2'b00:   load_start = neg_four_n + 8'd4;
            default: load_start = neg_four_n;
        endcase
        if (load_n == 5'd0) begin
            load_start = '0;
            load_wb    = '0;
        end
    end

    assign list_clr = list_q & ~(16'h0001 << reg_num_q);

    lsm_prio_enc u_load_enc (
        .vec   (IR[15:0]),
        .index (load_idx),
        .valid (load_vld)
    );

    lsm_prio_enc u_next_enc (
        .vec   (list_clr),
        .index (next_idx),
        .valid (unused_next_vld)
    );

    always_comb begin
        state_d     = state_q;
        list_d      = list_q;
        reg_num_d   = reg_num_q;
        cnt_d       = cnt_q;
        start_off_d = start_off_q;
        wb_off_d    = wb_off_q;
        if (LSM_EN) begin
            case (LSM_IN)
                CMD_LOAD: begin
                    list_d      = IR[15:0];
                    cnt_d       = load_n;
                    reg_num_d   = load_idx;
                    state_d     = load_vld ? ST_ACTIVE : ST_DONE;
                    start_off_d = load_start;
                    wb_off_d    = load_wb;
                end
                CMD_NEXT: begin
                    if (state_q == ST_ACTIVE) begin
                        list_d = list_clr;
                        cnt_d  = cnt_q - 5'd1;
                        // The final register keeps its number visible while DONE.
                        if (cnt_q == 5'd1) state_d = ST_DONE;
                        else reg_num_d = next_idx;
                    end
                end
                CMD_CLEAR: begin
                    state_d     = ST_IDLE;
                    list_d      = '0;
                    reg_num_d   = '0;
                    cnt_d       = '0;
                    start_off_d = '0;
                    wb_off_d    = '0;
                end
                default: ;
            endcase
        end
        end_d = ((state_d == ST_ACTIVE) && (cnt_d == 5'd1)) || (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            list_q      <= '0;
            reg_num_q   <= '0;
            cnt_q       <= '0;
            start_off_q <= '0;
            wb_off_q    <= '0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            list_q      <= list_d;
            reg_num_q   <= reg_num_d;
            cnt_q       <= cnt_d;
            start_off_q <= start_off_d;
            wb_off_q    <= wb_off_d;
            end_q       <= end_d;
        end
    end

    assign LSM_END      = end_q;
    assign REG_NUM      = reg_num_q;
    assign CNT          = cnt_q;
    assign START_OFFSET = start_off_q;
    assign WB_OFFSET    = wb_off_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: queue-based reference model, directed cases and random traffic.
module tb_lsm_sequencer;
    import lsm_pkg::*;

    logic CLK;
    logic RESET;

    lsm_sequencer_if bus (.clk(CLK));

    lsm_sequencer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IR           (bus.ir),
        .LSM_EN       (bus.lsm_en),
        .LSM_IN       (bus.lsm_in),
        .LSM_DETECT   (bus.lsm_detect),
        .LSM_END      (bus.lsm_end),
        .REG_NUM      (bus.reg_num),
        .CNT          (bus.cnt),
        .START_OFFSET (bus.start_offset),
        .WB_OFFSET    (bus.wb_offset)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [3:0] reg_num;
        logic [4:0] cnt;
        logic [7:0] so;
        logic [7:0] wo;
        logic       lend;
        logic       det;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: remaining registers as an ascending list of indices.
    int         m_regs[$];
    bit         m_active, m_done;
    logic [3:0] m_reg;
    logic [7:0] m_so, m_wo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_regs   = {};
        m_active = 0;
        m_done   = 0;
        m_reg    = '0;
        m_so     = '0;
        m_wo     = '0;
    endtask

    task automatic model_step(input logic en, input logic [2:0] cmd, input logic [31:0] ir);
        int n, so, wo;
        if (!en) return;
        if (cmd == CMD_LOAD) begin
            m_regs = {};
            for (int i = 0; i < 16; i++) if (ir[i]) m_regs.push_back(i);
            n = m_regs.size();
            if (n == 0) begin
                so = 0; wo = 0;
                m_active = 0; m_done = 1; m_reg = '0;
            end else begin
                wo = ir[23] ? 4 * n : -4 * n;
                if (ir[24]) so = ir[23] ? 4 : -4 * n;
                else        so = ir[23] ? 0 : -4 * n + 4;
                m_active = 1; m_done = 0; m_reg = 4'(m_regs[0]);
            end
            m_so = 8'(so);
            m_wo = 8'(wo);
        end else if (cmd == CMD_NEXT) begin
            if (m_active) begin
                void'(m_regs.pop_front());
                if (m_regs.size() == 0) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_reg = 4'(m_regs[0]);
                end
            end
        end else if (cmd == CMD_CLEAR) begin
            model_reset();
        end
    endtask

    function automatic exp_t snapshot(input logic [31:0] ir);
        exp_t e;
        e.reg_num = m_reg;
        e.cnt     = 5'(m_regs.size());
        e.so      = m_so;
        e.wo      = m_wo;
        e.lend    = (m_active && m_regs.size() == 1) || m_done;
        e.det     = (ir[27:25] == 3'b100);
        return e;
    endfunction

    task automatic drive(input logic en, input logic [2:0] cmd, input logic [31:0] ir);
        @(negedge CLK);
        bus.lsm_en = en;
        bus.lsm_in = cmd;
        bus.ir     = ir;
        model_step(en, cmd, ir);
        exp_q.push_back(snapshot(ir));
    endtask

    task automatic chk_now(input string tag, input logic [3:0] r, input logic [4:0] c,
                           input logic e, input logic [7:0] so, input logic [7:0] wo);
        @(posedge CLK);
        #2;
        chk({tag, "_reg"}, 32'(bus.reg_num), 32'(r));
        chk({tag, "_cnt"}, 32'(bus.cnt), 32'(c));
        chk({tag, "_end"}, 32'(bus.lsm_end), 32'(e));
        chk({tag, "_so"}, 32'(bus.start_offset), 32'(so));
        chk({tag, "_wo"}, 32'(bus.wb_offset), 32'(wo));
    endtask

    // Monitor: every cycle with an outstanding expectation is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_reg_num", 32'(bus.reg_num), 32'(e.reg_num));
                chk("sb_cnt", 32'(bus.cnt), 32'(e.cnt));
                chk("sb_start_off", 32'(bus.start_offset), 32'(e.so));
                chk("sb_wb_off", 32'(bus.wb_offset), 32'(e.wo));
                chk("sb_lsm_end", 32'(bus.lsm_end), 32'(e.lend));
                chk("sb_detect", 32'(bus.lsm_detect), 32'(e.det));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir;
        logic [2:0]  cmd;
        logic        en;
        int          r, k;

        RESET      = 1'b1;
        bus.ir     = '0;
        bus.lsm_en = 1'b0;
        bus.lsm_in = CMD_NOP;
        model_reset();
        #1 RESET = 1'b0;
        #2;
        chk("rst_reg", 32'(bus.reg_num), 0);
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_end", 32'(bus.lsm_end), 0);
        chk("rst_so", 32'(bus.start_offset), 0);
        chk("rst_wo", 32'(bus.wb_offset), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;

        // LDMIA SP!,{R4,PC}
        drive(1, CMD_LOAD, 32'hE8BD8010);
        chk_now("ldm_load", 4'd4, 5'd2, 1'b0, 8'h00, 8'h08);
        drive(1, CMD_NEXT, 32'hE8BD8010);
        chk_now("ldm_next1", 4'd15, 5'd1, 1'b1, 8'h00, 8'h08);
        drive(1, CMD_NEXT, 32'hE8BD8010);
        chk_now("ldm_next2", 4'd15, 5'd0, 1'b1, 8'h00, 8'h08);
        drive(1, CMD_NEXT, 32'hE8BD8010);
        drive(1, CMD_NOP, 32'hE3A00001);

        // STMDB SP!,{R0-R3}
        drive(1, CMD_LOAD, 32'hE92D000F);
        chk_now("stm_load", 4'd0, 5'd4, 1'b0, 8'hF0, 8'hF0);
        for (int i = 0; i < 3; i++) drive(1, CMD_NEXT, 32'hE92D000F);
        drive(1, CMD_NOP, 32'hE3A00001);

        // Empty list, then a full list to reach n=16
        drive(1, CMD_LOAD, 32'hE8900000);
        chk_now("empty_load", 4'd0, 5'd0, 1'b1, 8'h00, 8'h00);
        drive(1, CMD_NEXT, 32'hE8900000);
        drive(1, CMD_LOAD, 32'hE910FFFF);
        drive(1, CMD_NEXT, 32'hE910FFFF);

        // Enable gating and CLEAR
        drive(1, CMD_LOAD, 32'hE8BD00FF);
        drive(1, CMD_NEXT, 32'hE8BD00FF);
        drive(0, CMD_NEXT, 32'hE8BD00FF);
        drive(0, CMD_CLEAR, 32'hE8BD00FF);
        drive(1, CMD_CLEAR, 32'hE8BD00FF);
        chk_now("clear", 4'd0, 5'd0, 1'b0, 8'h00, 8'h00);

        // Asynchronous reset between edges, mid-sequence
        drive(1, CMD_LOAD, 32'hE8BD00FF);
        drive(1, CMD_NEXT, 32'hE8BD00FF);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        chk("arst_reg", 32'(bus.reg_num), 0);
        chk("arst_cnt", 32'(bus.cnt), 0);
        chk("arst_end", 32'(bus.lsm_end), 0);
        chk("arst_so", 32'(bus.start_offset), 0);
        chk("arst_wo", 32'(bus.wb_offset), 0);
        model_reset();
        drive(0, CMD_NOP, 32'hE8BD00FF);
        RESET = 1'b1;
        drive(1, CMD_LOAD, 32'hE8BD8010);
        chk_now("post_rst_load", 4'd4, 5'd2, 1'b0, 8'h00, 8'h08);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            r  = $urandom_range(0, 99);
            en = ($urandom_range(0, 9) != 0);
            if (r < 12)      cmd = CMD_LOAD;
            else if (r < 80) cmd = CMD_NEXT;
            else if (r < 85) cmd = CMD_CLEAR;
            else if (r < 92) cmd = CMD_NOP;
            else             cmd = 3'(4 + $urandom_range(0, 3));
            ir = $urandom;
            if ($urandom_range(0, 1) == 1) ir[27:25] = 3'b100;
            k = $urandom_range(0, 7);
            if (k == 0)      ir[15:0] = 16'h0000;
            else if (k == 1) ir[15:0] = 16'hFFFF;
            else if (k == 2) ir[15:0] = 16'h0001 << $urandom_range(0, 15);
            else             ir[15:0] = 16'($urandom & $urandom);
            drive(en, cmd, ir);
        end

        repeat (3) @(posedge CLK);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
